pu_window_sequencer: RTL and testbench
======================================

// Module: pu_window_sequencer
// PURPOSE
//  Upstream feeder for the PU MAC stage. Collects a serial stream of 5-bit activations
//  into a 4-deep window and holds 4 programmable 5-bit weights. When the window is full
//  it drives a1..a4/w1..w4 stable for the PU's pipeline latency. It then captures the
//  PU's 5-bit activated output and offers it downstream on a valid/ready handshake.
// PARAMETERS
//  DW   5   activation/weight/result width; must match PU ports
//  LAT  2   PU register stages between a/w inputs and a valid `out` (min 1)
// PORTS
//  clk        in   1    clock, rising-edge
//  rst        in   1    asynchronous, active-low reset
//  in_valid   in   1    activation sample valid
//  in_data    in   DW   activation sample (two's complement)
//  in_ready   out  1    sequencer accepts a sample this cycle
//  w_load     in   1    weight write strobe
//  w_idx      in   2    weight index 0..3 -> w1..w4
//  w_data     in   DW   weight value
//  a1..a4     out  DW   window to PU; a1 oldest, a4 newest
//  w1..w4     out  DW   weights to PU
//  pu_out     in   DW   PU result (combinational after its final register)
//  res_valid  out  1    res_data holds an unconsumed result
//  res_data   out  DW   captured PU result
//  res_ready  in   1    downstream accepts res_data
//  busy       out  1    state != FILL
// BEHAVIOUR
//  Reset (rst=0, async): state=FILL, fill_cnt=0, lat_cnt=0, a1..a4=0, w1..w4=0,
//   res_data=0, res_valid=0. Outputs in_ready=1 and busy=0 are decoded from state.
//  States FILL/RUN/DONE, all registered; in_ready = (state==FILL); busy = !in_ready.
//  FILL: on in_valid, shift a1<=a2, a2<=a3, a3<=a4, a4<=in_data and fill_cnt++.
//   If the accept makes fill_cnt==4 -> RUN with lat_cnt=0 (edge E0).
//  RUN: a/w frozen; in_valid ignored. State lasts exactly LAT+1 cycles (lat_cnt 0..LAT).
//   At the edge ending lat_cnt==LAT: res_data<=pu_out, res_valid<=1, go to DONE.
//   With LAT=2, pu_out is sampled at E3 (PU mul reg loads at E1, add reg at E2).
//  DONE: hold res_data/res_valid. Handshake on res_valid&&res_ready -> res_valid<=0,
//   go to FILL, fill_cnt reloaded (see CONFIGURATION). res_ready while !res_valid is ignored.
//  Weights: w_load writes w[w_idx] only in FILL; ignored in RUN/DONE so the PU inputs
//   stay stable. A w_load in the same FILL cycle as the 4th accept applies to that window.
//  fill_cnt is 3 bits and saturates at 4 (no wrap). lat_cnt is sized for LAT, no wrap.
//  No arithmetic is done here; values pass through bit-exact.
//  Reset mid-RUN/DONE aborts: any pending result is lost and the window is cleared.
// CONFIGURATION
//  SLIDE_WINDOW_EN defined: leaving DONE reloads fill_cnt=3 and keeps a1..a4. The next
//   single accept shifts in 1 sample and refires (stride 1; windows overlap by 3).
//  Undefined: leaving DONE reloads fill_cnt=0 and keeps a1..a4 (no clear). Four new
//   samples are needed per fire (stride 4, disjoint windows).
// TESTING
//  Reset: rst=0 mid-RUN, then release -> next cycle in_ready=1, res_valid=0, a*/w*=0.
//  Weights: w_load idx0..3 = 1,2,3,4 then stream 5,6,7,8.
//   Expected: w1..w4=1,2,3,4; a1..a4=5,6,7,8; busy rises the cycle after the 4th accept.
//  Latency: pu_out stub = 5'h1F, except 5'h0A in RUN cycle lat_cnt==2.
//   Expected: res_data=5'h0A and res_valid=1 exactly 3 cycles after entering RUN.
//  Backpressure: hold res_ready=0 for 10 cycles with in_valid=1.
//   Expected: res_data stable, in_ready=0, no sample consumed; res_ready=1 -> FILL next cycle.
//  Stride (SLIDE_WINDOW_EN off): after the 1st result, 3 accepts keep state=FILL and the 4th fires.
//   With the macro on, stream 9 after window 5..8 -> fires with a1..a4=6,7,8,9.
//  Blocked weights: w_load idx1=5'h1F during RUN -> w2 unchanged and the result is captured unaffected.

Source files
------------

// File: rtl/pu_window_sequencer.sv
// Window/weight feeder for the PU MAC stage: collects 4 activations, holds them
// stable for the PU latency, then offers the captured PU result on a valid/ready port.
// Optional build macro SLIDE_WINDOW_EN: stride-1 overlapping windows instead of stride-4.
module pu_window_sequencer #(
  parameter int unsigned DW  = 5,
  parameter int unsigned LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          w_load,
  input  logic [1:0]    w_idx,
  input  logic [DW-1:0] w_data,
  output logic [DW-1:0] a1,
  output logic [DW-1:0] a2,
  output logic [DW-1:0] a3,
  output logic [DW-1:0] a4,
  output logic [DW-1:0] w1,
  output logic [DW-1:0] w2,
  output logic [DW-1:0] w3,
  output logic [DW-1:0] w4,
  input  logic [DW-1:0] pu_out,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  input  logic          res_ready,
  output logic          busy
);

  localparam int unsigned LCW = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam logic [LCW-1:0] LAT_LAST = LCW'(LAT);

`ifdef SLIDE_WINDOW_EN
  localparam logic [2:0] FILL_RELOAD = 3'd3;
`else
  localparam logic [2:0] FILL_RELOAD = 3'd0;
`endif

  typedef enum logic [1:0] {FILL, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [2:0]     fill_cnt;
  logic [LCW-1:0] lat_cnt;
  logic           accept, fire, lat_done, handshake;

  assign accept    = (state_q == FILL) && in_valid;
  assign fire      = accept && (fill_cnt == 3'd3);
  assign lat_done  = (state_q == RUN) && (lat_cnt == LAT_LAST);
  assign handshake = (state_q == DONE) && res_valid && res_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FILL;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (fire)      state_d = RUN;
      RUN:     if (lat_done)  state_d = DONE;
      DONE:    if (handshake) state_d = FILL;
      default:                state_d = FILL;
    endcase
  end

  always_comb begin
    in_ready = (state_q == FILL);
    busy     = (state_q != FILL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_cnt  <= '0;
      lat_cnt   <= '0;
      a1        <= '0;
      a2        <= '0;
      a3        <= '0;
      a4        <= '0;
      w1        <= '0;
      w2        <= '0;
      w3        <= '0;
      w4        <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
    end else begin
      if (accept) begin
        a1       <= a2;
        a2       <= a3;
        a3       <= a4;
        a4       <= in_data;
        fill_cnt <= (fill_cnt == 3'd4) ? 3'd4 : fill_cnt + 3'd1;
      end
      // Weight writes only in FILL so the PU inputs stay frozen through RUN/DONE.
      if ((state_q == FILL) && w_load) begin
        case (w_idx)
          2'd0: w1 <= w_data;
          2'd1: w2 <= w_data;
          2'd2: w3 <= w_data;
          2'd3: w4 <= w_data;
          default: ;
        endcase
      end
      if (fire)
        lat_cnt <= '0;
      else if ((state_q == RUN) && !lat_done)
        lat_cnt <= lat_cnt + LCW'(1);
      if (lat_done) begin
        res_data  <= pu_out;
        res_valid <= 1'b1;
      end
      if (handshake) begin
        res_valid <= 1'b0;
        fill_cnt  <= FILL_RELOAD;
      end
    end
  end

endmodule

// File: tb/tb_pu_window_sequencer.sv
// Scoreboard bench for pu_window_sequencer; the PU is a stub driven per RUN cycle.
module tb_pu_window_sequencer;
  localparam int unsigned DW  = 5;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, w_load, res_valid, res_ready, busy;
  logic [DW-1:0] in_data, w_data, pu_out, res_data;
  logic [1:0]    w_idx;
  logic [DW-1:0] a1, a2, a3, a4, w1, w2, w3, w4;
  logic [DW-1:0] a_obs [4];
  logic [DW-1:0] w_obs [4];

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_a [4];
  logic [DW-1:0] exp_w [4];
  logic [DW-1:0] e;
  int mfill;

  pu_window_sequencer #(.DW(DW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .w_load(w_load), .w_idx(w_idx), .w_data(w_data),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4), .w1(w1), .w2(w2), .w3(w3), .w4(w4),
    .pu_out(pu_out), .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    a_obs[0] = a1; a_obs[1] = a2; a_obs[2] = a3; a_obs[3] = a4;
    w_obs[0] = w1; w_obs[1] = w2; w_obs[2] = w3; w_obs[3] = w4;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      exp_a[i] = '0;
      exp_w[i] = '0;
    end
    mfill = 0;
  endtask

  task automatic accept_sample(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    exp_a[0] = exp_a[1]; exp_a[1] = exp_a[2]; exp_a[2] = exp_a[3]; exp_a[3] = d;
    mfill++;
  endtask

  task automatic load_weight(input logic [1:0] idx, input logic [DW-1:0] d);
    w_load = 1'b1; w_idx = idx; w_data = d;
    tick();
    w_load = 1'b0;
    exp_w[idx] = d;
  endtask

  // Stub PU: 5'h1F except during the RUN cycle with lat_cnt==LAT; ends just after E3.
  task automatic run_pu(input logic [DW-1:0] v);
    tick();
    tick();
    pu_out = v;
    tick();
    pu_out = 5'h1F;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    res_ready = 1'b0;
`ifdef SLIDE_WINDOW_EN
    mfill = 3;
`else
    mfill = 0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    model_clear();
    tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    tests++; if (res_data !== 5'h00) begin fails++; $display("FAIL reset_res_data: got %h want 00", res_data); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (a_obs[i] !== 5'h00 || w_obs[i] !== 5'h00) begin
        fails++; $display("FAIL reset_aw[%0d]: got a=%h w=%h want 00", i, a_obs[i], w_obs[i]);
      end
    end
  endtask

  task automatic test_weights();
    for (int i = 0; i < 4; i++) load_weight(2'(i), 5'(i + 1));
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(5'h0A);
      accept_sample(5'(5 + i));
      if (i < 3) begin
        tests++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
          fails++; $display("FAIL weights_fill[%0d]: got in_ready=%b busy=%b want 1/0", i, in_ready, busy);
        end
      end
    end
    tests++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
      fails++; $display("FAIL weights_busy: got busy=%b in_ready=%b want 1/0", busy, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tests++; if (a_obs[i] !== exp_a[i]) begin fails++; $display("FAIL weights_a%0d: got %h want %h", i + 1, a_obs[i], exp_a[i]); end
      tests++; if (w_obs[i] !== exp_w[i]) begin fails++; $display("FAIL weights_w%0d: got %h want %h", i + 1, w_obs[i], exp_w[i]); end
    end
  endtask

  task automatic test_latency();
    tick();
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL latency_e1: got res_valid=%b want 0", res_valid); end
    tick();
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL latency_e2: got res_valid=%b want 0", res_valid); end
    pu_out = 5'h0A;
    tick();
    pu_out = 5'h1F;
    tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL latency_e3_valid: got %b want 1", res_valid); end
    tests++; if (exp_q.size() == 0) begin fails++; $display("FAIL latency_sb: got empty queue want entry"); end
    else begin
      e = exp_q.pop_front();
      if (res_data !== e) begin fails++; $display("FAIL latency_data: got %h want %h", res_data, e); end
    end
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 5'h15;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++; if (res_valid !== 1'b1 || res_data !== 5'h0A || in_ready !== 1'b0 || a4 !== exp_a[3] || a1 !== exp_a[0]) begin
        fails++; $display("FAIL backpressure[%0d]: got rv=%b data=%h in_ready=%b a1=%h a4=%h want 1/0a/0/%h/%h",
                          i, res_valid, res_data, in_ready, a1, a4, exp_a[0], exp_a[3]);
      end
    end
    handshake();
    tests++; if (in_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL backpressure_release: got in_ready=%b rv=%b busy=%b want 1/0/0", in_ready, res_valid, busy);
    end
  endtask

  task automatic test_stride();
    logic [DW-1:0] v;
`ifdef SLIDE_WINDOW_EN
    v = 5'd9;
`else
    v = 5'd11;
`endif
    while (mfill < 4) begin
      if (mfill == 3) exp_q.push_back(5'h13);
      accept_sample(v);
      v = v + 5'd1;
      if (mfill < 4) begin
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stride_fill: got in_ready=%b want 1", in_ready); end
      end
    end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL stride_fire: got busy=%b want 1", busy); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (a_obs[i] !== exp_a[i]) begin fails++; $display("FAIL stride_a%0d: got %h want %h", i + 1, a_obs[i], exp_a[i]); end
    end
    run_pu(5'h13);
    tests++; if (exp_q.size() == 0 || res_valid !== 1'b1) begin
      fails++; $display("FAIL stride_result: got rv=%b queue=%0d want 1/nonempty", res_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (res_data !== e) begin fails++; $display("FAIL stride_data: got %h want %h", res_data, e); end
    end
    handshake();
  endtask

  task automatic test_blocked_weights();
    logic [DW-1:0] v = 5'd20;
    while (mfill < 4) begin
      if (mfill == 3) begin
        exp_q.push_back(5'h07);
        w_load = 1'b1; w_idx = 2'd3; w_data = 5'h09;
        exp_w[3] = 5'h09;
      end
      accept_sample(v);
      w_load = 1'b0;
      v = v + 5'd1;
    end
    tests++; if (w4 !== exp_w[3]) begin fails++; $display("FAIL blocked_w4_same_cycle: got %h want %h", w4, exp_w[3]); end
    w_load = 1'b1; w_idx = 2'd1; w_data = 5'h1F;
    tick();
    w_load = 1'b0;
    tests++; if (w2 !== exp_w[1]) begin fails++; $display("FAIL blocked_w2: got %h want %h", w2, exp_w[1]); end
    tick();
    pu_out = 5'h07;
    tick();
    pu_out = 5'h1F;
    tests++; if (exp_q.size() == 0 || res_valid !== 1'b1) begin
      fails++; $display("FAIL blocked_result: got rv=%b queue=%0d want 1/nonempty", res_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (res_data !== e || w2 !== exp_w[1]) begin
        fails++; $display("FAIL blocked_data: got data=%h w2=%h want %h/%h", res_data, w2, e, exp_w[1]);
      end
    end
    handshake();
  endtask

  task automatic test_abort();
    logic [DW-1:0] v = 5'd24;
    while (mfill < 4) begin
      if (mfill == 3) exp_q.push_back(5'h11);
      accept_sample(v);
      v = v + 5'd1;
    end
    tick();
    #3;
    rst = 1'b0;
    exp_q.delete();
    model_clear();
    tick();
    rst = 1'b1;
    tick();
    tests++; if (in_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL abort_state: got in_ready=%b rv=%b busy=%b want 1/0/0", in_ready, res_valid, busy);
    end
    for (int i = 0; i < 4; i++) begin
      tests++; if (a_obs[i] !== exp_a[i] || w_obs[i] !== exp_w[i]) begin
        fails++; $display("FAIL abort_aw[%0d]: got a=%h w=%h want %h/%h", i, a_obs[i], w_obs[i], exp_a[i], exp_w[i]);
      end
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL sb_drain: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; w_load = 1'b0; w_idx = '0;
    w_data = '0; pu_out = 5'h1F; res_ready = 1'b0;
    model_clear();
    test_reset();
    test_weights();
    test_latency();
    test_backpressure();
    test_stride();
    test_blocked_weights();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
